// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - hobby-servo PWM frame generator with frame-boundary position latch
// Optional macro SERVO_SLEW_EN: rate-limit applied_pos by SLEW_STEP per frame.
module servo_pwm_driver #(
    parameter int PERIOD_CYCLES    = 1000000,
    parameter int MIN_PULSE_CYCLES = 50000,
    parameter int TICK_CYCLES      = 49,
    parameter int MAX_POS          = 1023,
    parameter int CNT_W            = 20,
    parameter int SLEW_STEP        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] position,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [9:0] applied_pos
);

    localparam longint MAX_PULSE = longint'(MIN_PULSE_CYCLES) + longint'(MAX_POS) * longint'(TICK_CYCLES);
    localparam int PL_W  = $clog2(MAX_PULSE + 1) + 1;
    localparam int CMP_W = (PL_W > CNT_W) ? PL_W : CNT_W;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [9:0] MAX_POS_V = 10'(MAX_POS);

    if (SLEW_STEP < 1) begin : gBadSlewStep
        $error("SLEW_STEP must be at least 1");
    end
    if (longint'(PERIOD_CYCLES) > (longint'(1) << CNT_W)) begin : gBadCntWidth
        $error("CNT_W too narrow for PERIOD_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

    state_e            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [PL_W-1:0]   pulseLen, pulseLenNext;
    logic [9:0]        appliedNext;
    logic [9:0]        target;
    logic [9:0]        latchPos;
    logic              pwmNext, frameStartNext, startFrame;

    assign target = (position > MAX_POS_V) ? MAX_POS_V : position;

`ifdef SERVO_SLEW_EN
    localparam logic [10:0] STEP = 11'(SLEW_STEP);
    logic [10:0] dist;

    // Move from the previous applied position toward the target, landing exactly when close enough.
    always_comb begin
        dist     = '0;
        latchPos = target;
        if (target >= applied_pos) begin
            dist = {1'b0, target} - {1'b0, applied_pos};
            if (dist > STEP) latchPos = applied_pos + STEP[9:0];
        end else begin
            dist = {1'b0, applied_pos} - {1'b0, target};
            if (dist > STEP) latchPos = applied_pos - STEP[9:0];
        end
    end
`else
    assign latchPos = target;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pulseLen    <= '0;
            applied_pos <= '0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            pulseLen    <= pulseLenNext;
            applied_pos <= appliedNext;
            pwm_out     <= pwmNext;
            frame_start <= frameStartNext;
        end
    end

    always_comb begin
        stateNext      = state;
        cntNext        = cnt;
        pulseLenNext   = pulseLen;
        appliedNext    = applied_pos;
        frameStartNext = 1'b0;
        startFrame     = 1'b0;
        pwmNext        = 1'b0;

        case (state)
            IDLE: begin
                if (enable) startFrame = 1'b1;
            end
            default: begin
                if (cnt == LAST_CYCLE) begin
                    if (enable) begin
                        startFrame = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
        endcase

        if (startFrame) begin
            cntNext        = '0;
            appliedNext    = latchPos;
            pulseLenNext   = PL_W'(MIN_PULSE_CYCLES) + PL_W'(latchPos) * PL_W'(TICK_CYCLES);
            frameStartNext = 1'b1;
            stateNext      = PULSE;
        end

        // An oversized pulse simply never ends inside the frame, so the output stays high.
        if (stateNext != IDLE) begin
            pwmNext   = CMP_W'(cntNext) < CMP_W'(pulseLenNext);
            stateNext = pwmNext ? PULSE : GAP;
        end
    end

    pulseFitsFrame: assert property (@(posedge clk) disable iff (reset)
        frame_start |-> (longint'(pulseLen) < longint'(PERIOD_CYCLES)));

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb/tb_servo_pwm_driver.sv - directed-vector bench for servo_pwm_driver
// Scaled frame: PERIOD 100, MIN_PULSE 10, TICK 1, MAX_POS 50.
module tb_servo_pwm_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] position = '0;
    logic       pwm_out;
    logic       frame_start;
    logic [9:0] applied_pos;

    int vectors = 0;
    int miscompares = 0;

    servo_pwm_driver #(
        .PERIOD_CYCLES(100),
        .MIN_PULSE_CYCLES(10),
        .TICK_CYCLES(1),
        .MAX_POS(50),
        .CNT_W(7),
        .SLEW_STEP(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .position(position),
        .pwm_out(pwm_out),
        .frame_start(frame_start),
        .applied_pos(applied_pos)
    );

    always #5 clk = ~clk;

    // Entered at the negedge of frame cycle 0; leaves at the negedge of cycle 99.
    task automatic runFrame(input int changeAt, input logic [9:0] newPos, input int dropAt,
                            output int high, output int fsCnt, output logic [9:0] ap0,
                            output bit apStable, output bit shapeOk);
        bit seenLow;
        seenLow  = 1'b0;
        high     = 0;
        fsCnt    = 0;
        ap0      = applied_pos;
        apStable = 1'b1;
        shapeOk  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (pwm_out === 1'b1) begin
                high++;
                if (seenLow) shapeOk = 1'b0;
            end else begin
                seenLow = 1'b1;
            end
            if (frame_start === 1'b1) fsCnt++;
            if (applied_pos !== ap0) apStable = 1'b0;
            if (c == changeAt) position = newPos;
            if (c == dropAt) enable = 1'b0;
        end
    endtask

    task automatic waitFrame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; position = '0;
        repeat (3) @(negedge clk);
        vectors++; if (pwm_out !== 1'b0) begin miscompares++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs got %b want 0", frame_start); end
        vectors++; if (applied_pos !== 10'd0) begin miscompares++; $display("FAIL reset_pos got %0d want 0", applied_pos); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (pwm_out !== 1'b0 || frame_start !== 1'b0) begin miscompares++; $display("FAIL idle_low got pwm=%b fs=%b want 0 0", pwm_out, frame_start); end
    endtask

    task automatic test_basic;
        int h, f; logic [9:0] ap; bit st, sh;
        position = 10'd20; enable = 1'b1;
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL start_latency got fs=%b want 1", frame_start); end
        runFrame(-1, '0, -1, h, f, ap, st, sh);
        vectors++; if (h !== 30) begin miscompares++; $display("FAIL basic_high got %0d want 30", h); end
        vectors++; if (f !== 1) begin miscompares++; $display("FAIL basic_fs_count got %0d want 1", f); end
        vectors++; if (ap !== 10'd20 || !st) begin miscompares++; $display("FAIL basic_pos got %0d stable=%0d want 20 stable=1", ap, st); end
        vectors++; if (!sh) begin miscompares++; $display("FAIL basic_shape got split pulse want single"); end
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL back_to_back got fs=%b want 1", frame_start); end
        runFrame(-1, '0, -1, h, f, ap, st, sh);
        vectors++; if (h !== 30 || f !== 1) begin miscompares++; $display("FAIL second_frame got high=%0d fs=%0d want 30 1", h, f); end
    endtask

    task automatic test_clamp;
        int h, f; logic [9:0] ap; bit st, sh;
        position = 10'd700;
        @(negedge clk);
        runFrame(-1, '0, -1, h, f, ap, st, sh);
        vectors++; if (ap !== 10'd50) begin miscompares++; $display("FAIL clamp_pos got %0d want 50", ap); end
        vectors++; if (h !== 60) begin miscompares++; $display("FAIL clamp_high got %0d want 60", h); end
        position = 10'd20;
    endtask

    task automatic test_midframe_change;
        int h, f; logic [9:0] ap; bit st, sh;
        @(negedge clk);
        runFrame(15, 10'd5, -1, h, f, ap, st, sh);
        vectors++; if (h !== 30 || ap !== 10'd20 || !st) begin miscompares++; $display("FAIL change_current got high=%0d pos=%0d stable=%0d want 30 20 1", h, ap, st); end
        vectors++; if (applied_pos !== 10'd20) begin miscompares++; $display("FAIL change_early got %0d want 20 at cycle 99", applied_pos); end
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1 || applied_pos !== 10'd5) begin miscompares++; $display("FAIL change_coincident got fs=%b pos=%0d want 1 5", frame_start, applied_pos); end
        runFrame(-1, '0, -1, h, f, ap, st, sh);
        vectors++; if (h !== 15 || ap !== 10'd5) begin miscompares++; $display("FAIL change_next got high=%0d pos=%0d want 15 5", h, ap); end
    endtask

    task automatic test_enable_drop;
        int h, f, idleHigh, idleFs; logic [9:0] ap; bit st, sh;
        @(negedge clk);
        runFrame(-1, '0, 40, h, f, ap, st, sh);
        vectors++; if (h !== 15 || f !== 1) begin miscompares++; $display("FAIL drop_complete got high=%0d fs=%0d want 15 1", h, f); end
        idleHigh = 0; idleFs = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) idleHigh++;
            if (frame_start !== 1'b0) idleFs++;
        end
        vectors++; if (idleHigh !== 0 || idleFs !== 0) begin miscompares++; $display("FAIL drop_idle got high=%0d fs=%0d want 0 0", idleHigh, idleFs); end
        enable = 1'b1;
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1 || pwm_out !== 1'b1 || applied_pos !== 10'd5) begin miscompares++; $display("FAIL reenable got fs=%b pwm=%b pos=%0d want 1 1 5", frame_start, pwm_out, applied_pos); end
    endtask

    task automatic test_async_reset;
        int h, f; logic [9:0] ap; bit st, sh;
        repeat (12) @(negedge clk);
        vectors++; if (pwm_out !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pwm got %b want 1", pwm_out); end
        reset = 1'b1; position = 10'd20;
        #1;
        vectors++; if (pwm_out !== 1'b0 || applied_pos !== 10'd0 || frame_start !== 1'b0) begin miscompares++; $display("FAIL async_reset got pwm=%b pos=%0d fs=%b want 0 0 0", pwm_out, applied_pos, frame_start); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL post_reset_start got fs=%b want 1", frame_start); end
        runFrame(-1, '0, -1, h, f, ap, st, sh);
        vectors++; if (h !== 30 || ap !== 10'd20) begin miscompares++; $display("FAIL post_reset_frame got high=%0d pos=%0d want 30 20", h, ap); end
    endtask

    task automatic test_slew;
        int h, f; logic [9:0] ap; bit st, sh, ok;
        int expPos [5] = '{8, 16, 24, 30, 30};
        reset = 1'b1; enable = 1'b0; position = 10'd30;
        @(negedge clk);
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitFrame(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL slew_timeout frame %0d got none want frame_start", i); end
            runFrame(-1, '0, -1, h, f, ap, st, sh);
            vectors++; if (ap !== 10'(expPos[i]) || h !== 10 + expPos[i]) begin miscompares++; $display("FAIL slew_frame%0d got pos=%0d high=%0d want %0d %0d", i, ap, h, expPos[i], 10 + expPos[i]); end
        end
    endtask

    initial begin
`ifdef SERVO_SLEW_EN
        test_reset();
        test_slew();
`else
        test_reset();
        test_basic();
        test_clamp();
        test_midframe_change();
        test_enable_drop();
        test_async_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
Downstream stage of the servo source mux in the chip dispenser. Consumes the selected 10-bit servo position, which comes from either the normal sort path or the maintenance test path. Produces the standard hobby-servo PWM waveform: a 20 ms frame with a 1–2 ms high pulse. The position is sampled only at frame boundaries, so mux switching or sorter updates never produce a truncated or stretched pulse.

Parameters:
PERIOD_CYCLES, 1000000, frame length in clk cycles (20 ms at 50 MHz)
MIN_PULSE_CYCLES, 50000, high time for position 0 (1 ms)
TICK_CYCLES, 49, extra high cycles per position LSB
MAX_POS, 1023, positions above this are clamped to it
CNT_W, 20, frame counter width; must hold PERIOD_CYCLES-1
SLEW_STEP, 8, max position change per frame (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = generate frames; 0 = idle low after the current frame
position  input  10  requested servo position (mux output)
pwm_out  output  1  registered servo control signal
frame_start  output  1  one-cycle pulse on the first cycle of each frame
applied_pos  output  10  position in effect for the current frame

Behaviour:
- Reset values (asynchronous, take effect immediately, even mid-pulse):
  - pwm_out=0, frame_start=0, applied_pos=0
  - frame counter=0, state=IDLE
- States: IDLE, PULSE, GAP.
- IDLE:
  - pwm_out=0.
  - If enable=1 at a clk edge, the next cycle is frame cycle 0 (PULSE).
- Frame-start latch:
  - On the edge entering cycle 0, latch applied_pos = min(position, MAX_POS).
  - Compute pulse_len = MIN_PULSE_CYCLES + applied_pos*TICK_CYCLES. Use width sufficient for the product, with no truncation.
  - frame_start=1 during cycle 0 only.
- PULSE: pwm_out=1 for frame cycles 0..pulse_len-1, then GAP.
- GAP: pwm_out=0 for cycles pulse_len..PERIOD_CYCLES-1.
- Frame end, at cycle PERIOD_CYCLES-1:
  - If enable=1, the counter wraps to 0 and the next frame starts with a fresh latch. There are no idle cycles between back-to-back frames.
  - Otherwise go to IDLE.
- Mid-frame changes:
  - position changes are ignored until the next frame boundary. Latency is the value present on the cycle before cycle 0.
  - enable deassert completes the current frame in full; no early pulse termination.
- pulse_len >= PERIOD_CYCLES is a parameter error. A behavioural assertion flags it; RTL then holds pwm_out=1 for the whole frame.
- applied_pos is stable for an entire frame and changes only coincident with frame_start.

Optional Feature:
Macro SERVO_SLEW_EN.
- Defined:
  - At each frame latch, applied_pos moves toward min(position, MAX_POS) by at most SLEW_STEP.
  - It lands exactly on the target when the remaining distance is <= SLEW_STEP.
  - Starting point is the previous applied_pos (0 after reset), preserved across IDLE periods.
- Undefined: applied_pos jumps straight to the clamped target; SLEW_STEP is unused.

Test Plan:
All scenarios use PERIOD_CYCLES=100, MIN_PULSE_CYCLES=10, TICK_CYCLES=1, MAX_POS=50 unless noted.
1. Reset, enable=1, position=20 held → frame_start every 100 cycles; pwm_out high exactly 30 cycles then low 70; applied_pos=20.
2. position=700 → clamped; applied_pos=50, high 60 cycles.
3. position changes 20→5 at frame cycle 15 → current frame stays 30 high; next frame 15 high, applied_pos=5 coincident with frame_start.
4. enable drops at frame cycle 40 → frame completes to cycle 99; pwm_out stays 0 afterward; no further frame_start. Re-assert → new frame starts the following cycle.
5. reset asserted at frame cycle 12 (pwm_out=1) → pwm_out, applied_pos, frame_start go 0 immediately without a clk edge; after release with enable=1, a full 30-cycle pulse frame.
6. SERVO_SLEW_EN, SLEW_STEP=8, position=30 from reset → applied_pos sequence 8,16,24,30,30 over successive frames.
